// File: rtl/song_pkg.sv
// Shared widths, ROM entry layout, FSM encodings and the song table for song_reader.
package song_pkg;

  localparam int unsigned SONG_BITS  = 2;
  localparam int unsigned INDEX_BITS = 5;
  localparam int unsigned NOTE_W     = 6;
  localparam int unsigned ENTRY_W    = 16;

  localparam int unsigned ADV_BIT    = 15;
  localparam int unsigned NOTE_LSB   = 9;
  localparam int unsigned DUR_LSB    = 3;

  // {is_advance, note} of an end marker
  localparam logic [NOTE_W:0] END_MARK = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_DECODE,
    S_ISSUE,
    S_WAIT_BEATS,
    S_DONE
  } state_t;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic adv,
                                                  input logic [NOTE_W-1:0] note,
                                                  input logic [NOTE_W-1:0] dur);
    return {adv, note, dur, 3'b000};
  endfunction

  // Song contents; unlisted slots read as end markers, song 3 fills every slot.
  function automatic logic [ENTRY_W-1:0] song_table(input int unsigned song,
                                                    input int unsigned idx);
    logic [ENTRY_W-1:0] w;
    w = '0;
    case (song)
      0: begin
        case (idx)
          0:       w = mk_entry(1'b0, 6'd1,  6'd8);
          1:       w = mk_entry(1'b0, 6'd51, 6'd3);
          2:       w = mk_entry(1'b1, 6'd0,  6'd4);
          3:       w = mk_entry(1'b0, 6'd10, 6'd5);
          default: w = '0;
        endcase
      end
      1: begin
        if (idx == 0) w = mk_entry(1'b0, 6'd57, 6'd5);
      end
      2: begin
        case (idx)
          0:       w = mk_entry(1'b0, 6'd33, 6'd2);
          1:       w = mk_entry(1'b0, 6'd40, 6'd7);
          default: w = '0;
        endcase
      end
      default: w = mk_entry(1'b0, NOTE_W'(idx + 1), NOTE_W'(1));
    endcase
    return w;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous song ROM, one-cycle read latency, address {song, index}.
module song_rom #(
  parameter int unsigned SONG_BITS  = song_pkg::SONG_BITS,
  parameter int unsigned INDEX_BITS = song_pkg::INDEX_BITS
) (
  input  logic                             clk,
  input  logic [SONG_BITS+INDEX_BITS-1:0]  addr,
  output logic [song_pkg::ENTRY_W-1:0]     data
);
  import song_pkg::*;

  always_ff @(posedge clk) begin
    data <= song_table(32'(addr[SONG_BITS+INDEX_BITS-1:INDEX_BITS]),
                       32'(addr[INDEX_BITS-1:0]));
  end

endmodule

// File: rtl/song_reader.sv
// Walks a song's note/rest list from song_rom and feeds note loads to chords,
// timing rests on beat pulses.
module song_reader #(
  parameter int unsigned SONG_BITS  = song_pkg::SONG_BITS,
  parameter int unsigned INDEX_BITS = song_pkg::INDEX_BITS,
  parameter int unsigned NOTE_W     = song_pkg::NOTE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song,
  input  logic                 beat,
  input  logic                 player_available,
  output logic                 new_note,
  output logic [NOTE_W-1:0]    note_to_load,
  output logic [NOTE_W-1:0]    duration_to_load,
  output logic                 play_enable,
  output logic                 song_done
);
  import song_pkg::*;

  state_t                  state, state_nx, step_state;
  logic [SONG_BITS-1:0]    song_q, song_q_nx;
  logic [INDEX_BITS-1:0]   index, index_nx, step_index;
  logic [NOTE_W-1:0]       beat_cnt, beat_cnt_nx;
  logic [ENTRY_W-1:0]      rom_data;
  logic                    adv_q;
  logic [NOTE_W-1:0]       note_q, dur_q;
  logic [NOTE_W-1:0]       note_hold, dur_hold;
  logic                    entry_ld;
  logic                    running;
  logic                    rsvd_unused;

  song_rom #(
    .SONG_BITS  (SONG_BITS),
    .INDEX_BITS (INDEX_BITS)
  ) u_rom (
    .clk  (clk),
    .addr ({song_q, index}),
    .data (rom_data)
  );

  assign rsvd_unused = ^rom_data[DUR_LSB-1:0];
  assign running     = (state != S_IDLE) && (state != S_DONE);

  // The last slot of a song finishes the song instead of wrapping the index.
  assign step_state  = (index == '1) ? S_DONE : S_FETCH;
  assign step_index  = index + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      song_q      <= '0;
      index       <= '0;
      beat_cnt    <= '0;
      adv_q       <= 1'b0;
      note_q      <= '0;
      dur_q       <= '0;
      note_hold   <= '0;
      dur_hold    <= '0;
      play_enable <= 1'b0;
    end else begin
      state       <= state_nx;
      song_q      <= song_q_nx;
      index       <= index_nx;
      beat_cnt    <= beat_cnt_nx;
      play_enable <= play;
      if (entry_ld) begin
        adv_q  <= rom_data[ADV_BIT];
        note_q <= rom_data[NOTE_LSB +: NOTE_W];
        dur_q  <= rom_data[DUR_LSB +: NOTE_W];
      end
      if (new_note) begin
        note_hold <= note_q;
        dur_hold  <= dur_q;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    song_q_nx   = song_q;
    index_nx    = index;
    beat_cnt_nx = beat_cnt;
    entry_ld    = 1'b0;
    new_note    = 1'b0;

    if (running && (song != song_q)) begin
      song_q_nx   = song;
      index_nx    = '0;
      beat_cnt_nx = '0;
      state_nx    = S_FETCH;
    end else begin
      case (state)
        S_IDLE: begin
          if (play) begin
            song_q_nx = song;
            index_nx  = '0;
            state_nx  = S_FETCH;
          end
        end
        S_FETCH: begin
          if (play) state_nx = S_WAIT_ROM;
        end
        S_WAIT_ROM: begin
          if (play) begin
            entry_ld = 1'b1;
            state_nx = S_DECODE;
          end
        end
        S_DECODE: begin
          if (play) begin
            if ({adv_q, note_q} == END_MARK) begin
              state_nx = S_DONE;
            end else if (adv_q && (dur_q == '0)) begin
              index_nx = step_index;
              state_nx = step_state;
            end else if (adv_q) begin
              beat_cnt_nx = dur_q;
              state_nx    = S_WAIT_BEATS;
            end else begin
              state_nx = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (play && player_available) begin
            new_note = 1'b1;
            index_nx = step_index;
            state_nx = step_state;
          end
        end
        S_WAIT_BEATS: begin
          if (play && beat) begin
            if (beat_cnt == NOTE_W'(1)) begin
              index_nx = step_index;
              state_nx = step_state;
            end else begin
              beat_cnt_nx = beat_cnt - 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!play || (song != song_q)) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign song_done        = (state == S_DONE);
  assign note_to_load     = new_note ? note_q : note_hold;
  assign duration_to_load = new_note ? dur_q  : dur_hold;

endmodule
